// File: rtl/branch_tag_predictor.sv
// branch_tag_predictor
//   Issue-side companion of the branch execution unit. Hands out one of four
//   2-bit branch tags together with a BHT-based taken prediction for each
//   conditional branch. It consumes branch results, frees their tags and
//   trains a table of 2-bit saturating counters. On a misprediction it raises
//   a same-cycle flush that carries the redirect PC and the set of younger
//   tags to kill.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   dec_br_valid      decoder presents a conditional branch
//   dec_br_pc         branch PC
//   dec_br_target     branch target (PC + imm)
//   dec_br_grant      branch accepted, tag/pred valid
//   dec_br_tag        allocated tag (lowest free, 0 when none)
//   dec_br_pred       predicted taken
//   pred_next_pc      fetch PC after the branch
//   br_result_en      branch unit result valid
//   br_result_tag     tag being resolved
//   br_result_addr    resolved next PC
//   br_mis_taken      prediction was wrong
//   flush_en          misprediction redirect
//   flush_addr        redirect PC
//   flush_kill_mask   tags younger than the mispredicted one
//   tag_busy          outstanding tags
//   tags_full         all four tags busy
module branch_tag_predictor #(
    parameter int ADDR_W    = 32,
    parameter int BHT_IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_br_valid,
    input  logic [ADDR_W-1:0] dec_br_pc,
    input  logic [ADDR_W-1:0] dec_br_target,
    output logic              dec_br_grant,
    output logic [1:0]        dec_br_tag,
    output logic              dec_br_pred,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              br_result_en,
    input  logic [1:0]        br_result_tag,
    input  logic [ADDR_W-1:0] br_result_addr,
    input  logic              br_mis_taken,
    output logic              flush_en,
    output logic [ADDR_W-1:0] flush_addr,
    output logic [3:0]        flush_kill_mask,
    output logic [3:0]        tag_busy,
    output logic              tags_full
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    // Registered state
    logic [3:0]           busy_r;
    logic [3:0]           younger_r [4];   // younger_r[i][j]: j allocated after i
    logic [3:0]           pred_r;
    logic [BHT_IDX_W-1:0] idx_r [4];
    logic [1:0]           bht_r [BHT_N];

    // Combinational helpers
    logic                 res_valid_s;
    logic                 flush_s;
    logic [3:0]           kill_s;
    logic [3:0]           clear_s;
    logic [1:0]           alloc_tag_s;
    logic [3:0]           alloc_oh_s;
    logic                 grant_s;
    logic [BHT_IDX_W-1:0] dec_idx_s;
    logic                 pred_s;
    logic [ADDR_W-1:0]    seq_pc_s;
    logic [BHT_IDX_W-1:0] upd_idx_s;
    logic                 actual_s;
    logic [1:0]           bht_new_s;
    logic [3:0]           younger_nxt_s [4];

    // 2-bit saturating counter step towards taken (up) or not-taken (down).
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    // Result decode: valid resolve, flush and the set of tags to release.
    always_comb begin
        res_valid_s = br_result_en & busy_r[br_result_tag];
        flush_s     = res_valid_s & br_mis_taken;
        if (flush_s) begin
            kill_s = younger_r[br_result_tag] & busy_r;
        end else begin
            kill_s = 4'b0000;
        end
        if (res_valid_s) begin
            clear_s = (4'b0001 << br_result_tag) | kill_s;
        end else begin
            clear_s = 4'b0000;
        end
        // Only the resolved tag trains the BHT; killed tags never do.
        upd_idx_s = idx_r[br_result_tag];
        actual_s  = pred_r[br_result_tag] ^ br_mis_taken;
        bht_new_s = sat_update(bht_r[upd_idx_s], actual_s);
    end

    // Allocation side: lowest free tag, prediction lookup and grant.
    always_comb begin
        if (!busy_r[0]) begin
            alloc_tag_s = 2'd0;
        end else if (!busy_r[1]) begin
            alloc_tag_s = 2'd1;
        end else if (!busy_r[2]) begin
            alloc_tag_s = 2'd2;
        end else if (!busy_r[3]) begin
            alloc_tag_s = 2'd3;
        end else begin
            alloc_tag_s = 2'd0;
        end
        // Grant works off registered busy, so a tag freed this cycle is not reused yet.
        grant_s   = dec_br_valid & ~(&busy_r) & ~flush_s;
        dec_idx_s = dec_br_pc[BHT_IDX_W+1:2];
        pred_s    = bht_r[dec_idx_s][1];
        seq_pc_s  = dec_br_pc + ADDR_W'(4);
        if (grant_s) begin
            alloc_oh_s = 4'b0001 << alloc_tag_s;
        end else begin
            alloc_oh_s = 4'b0000;
        end
    end

    // Next age matrix: released tags lose row and column, a new tag starts
    // with an empty row and becomes younger than every currently busy tag.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (clear_s[i] | clear_s[j]) begin
                    younger_nxt_s[i][j] = 1'b0;
                end else if (alloc_oh_s[i]) begin
                    younger_nxt_s[i][j] = 1'b0;
                end else if (alloc_oh_s[j]) begin
                    younger_nxt_s[i][j] = busy_r[i];
                end else begin
                    younger_nxt_s[i][j] = younger_r[i][j];
                end
            end
        end
    end

    // Output drive; everything reads zero while reset is asserted.
    always_comb begin
        if (rst) begin
            dec_br_grant    = 1'b0;
            dec_br_tag      = 2'd0;
            dec_br_pred     = 1'b0;
            pred_next_pc    = {ADDR_W{1'b0}};
            flush_en        = 1'b0;
            flush_addr      = {ADDR_W{1'b0}};
            flush_kill_mask = 4'b0000;
            tag_busy        = 4'b0000;
            tags_full       = 1'b0;
        end else begin
            dec_br_grant    = grant_s;
            dec_br_tag      = alloc_tag_s;
            dec_br_pred     = pred_s;
            pred_next_pc    = pred_s ? dec_br_target : seq_pc_s;
            flush_en        = flush_s;
            flush_addr      = flush_s ? br_result_addr : {ADDR_W{1'b0}};
            flush_kill_mask = kill_s;
            tag_busy        = busy_r;
            tags_full       = &busy_r;
        end
    end

    // State update: tag bookkeeping, per-tag prediction info and BHT training.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 4'b0000;
            pred_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                younger_r[i] <= 4'b0000;
                idx_r[i]     <= {BHT_IDX_W{1'b0}};
            end
            for (int b = 0; b < BHT_N; b++) begin
                bht_r[b] <= 2'b01;
            end
        end else begin
            busy_r <= (busy_r & ~clear_s) | alloc_oh_s;
            for (int i = 0; i < 4; i++) begin
                younger_r[i] <= younger_nxt_s[i];
            end
            if (grant_s) begin
                pred_r[alloc_tag_s] <= pred_s;
                idx_r[alloc_tag_s]  <= dec_idx_s;
            end
            if (res_valid_s) begin
                bht_r[upd_idx_s] <= bht_new_s;
            end
        end
    end

endmodule

// File: tb/tb_branch_tag_predictor.sv
module tb_branch_tag_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_br_valid;
    logic [31:0] dec_br_pc;
    logic [31:0] dec_br_target;
    logic        dec_br_grant;
    logic [1:0]  dec_br_tag;
    logic        dec_br_pred;
    logic [31:0] pred_next_pc;
    logic        br_result_en;
    logic [1:0]  br_result_tag;
    logic [31:0] br_result_addr;
    logic        br_mis_taken;
    logic        flush_en;
    logic [31:0] flush_addr;
    logic [3:0]  flush_kill_mask;
    logic [3:0]  tag_busy;
    logic        tags_full;

    int total = 0;
    int bad   = 0;

    // Reference model: tag ages kept as allocation sequence numbers,
    // BHT kept as integer counters in 0..3.
    bit          m_busy [4];
    int unsigned m_seq  [4];
    bit          m_pred [4];
    int          m_idx  [4];
    int          m_bht  [64];
    int unsigned m_cnt = 0;

    branch_tag_predictor #(.ADDR_W(32), .BHT_IDX_W(6)) dut (
        .clk(clk), .rst(rst),
        .dec_br_valid(dec_br_valid), .dec_br_pc(dec_br_pc), .dec_br_target(dec_br_target),
        .dec_br_grant(dec_br_grant), .dec_br_tag(dec_br_tag), .dec_br_pred(dec_br_pred),
        .pred_next_pc(pred_next_pc),
        .br_result_en(br_result_en), .br_result_tag(br_result_tag),
        .br_result_addr(br_result_addr), .br_mis_taken(br_mis_taken),
        .flush_en(flush_en), .flush_addr(flush_addr), .flush_kill_mask(flush_kill_mask),
        .tag_busy(tag_busy), .tags_full(tags_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_busy[k] = 1'b0;
        for (int b = 0; b < 64; b++) m_bht[b] = 1;
    endtask

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    // One clock cycle: drive inputs, check all outputs against the model, advance the model.
    task automatic cyc(input logic r, input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic ren, input logic [1:0] rt, input logic [31:0] ra, input logic mis);
        bit          res_v, fl, full, grant, pred, actual;
        logic [3:0]  kill, busyv;
        int          t, ix;
        logic [31:0] npc;
        @(negedge clk);
        rst = r; dec_br_valid = v; dec_br_pc = pc; dec_br_target = tgt;
        br_result_en = ren; br_result_tag = rt; br_result_addr = ra; br_mis_taken = mis;
        #1;
        full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            busyv[k] = m_busy[k];
            if (!m_busy[k]) full = 1'b0;
        end
        res_v = ren && m_busy[rt];
        fl    = res_v && mis;
        kill  = 4'b0000;
        if (fl) begin
            for (int k = 0; k < 4; k++) if (m_busy[k] && m_seq[k] > m_seq[rt]) kill[k] = 1'b1;
        end
        t = 0;
        for (int k = 3; k >= 0; k--) if (!m_busy[k]) t = k;
        pred  = m_bht[pc_idx(pc)] >= 2;
        npc   = pred ? tgt : pc + 32'd4;
        grant = v && !full && !fl;
        if (r) begin
            chk("grant", {31'd0, dec_br_grant}, 32'd0);
            chk("tag", {30'd0, dec_br_tag}, 32'd0);
            chk("pred", {31'd0, dec_br_pred}, 32'd0);
            chk("next_pc", pred_next_pc, 32'd0);
            chk("flush_en", {31'd0, flush_en}, 32'd0);
            chk("flush_addr", flush_addr, 32'd0);
            chk("kill", {28'd0, flush_kill_mask}, 32'd0);
            chk("busy", {28'd0, tag_busy}, 32'd0);
            chk("full", {31'd0, tags_full}, 32'd0);
            model_reset();
        end else begin
            chk("grant", {31'd0, dec_br_grant}, {31'd0, grant});
            chk("tag", {30'd0, dec_br_tag}, 32'(t));
            chk("pred", {31'd0, dec_br_pred}, {31'd0, pred});
            chk("next_pc", pred_next_pc, npc);
            chk("flush_en", {31'd0, flush_en}, {31'd0, fl});
            chk("flush_addr", flush_addr, fl ? ra : 32'd0);
            chk("kill", {28'd0, flush_kill_mask}, {28'd0, kill});
            chk("busy", {28'd0, tag_busy}, {28'd0, busyv});
            chk("full", {31'd0, tags_full}, {31'd0, full});
            if (res_v) begin
                ix     = m_idx[rt];
                actual = m_pred[rt] ^ mis;
                if (actual) begin
                    if (m_bht[ix] < 3) m_bht[ix]++;
                end else begin
                    if (m_bht[ix] > 0) m_bht[ix]--;
                end
                m_busy[rt] = 1'b0;
                for (int k = 0; k < 4; k++) if (kill[k]) m_busy[k] = 1'b0;
            end
            if (grant) begin
                m_cnt++;
                m_busy[t] = 1'b1;
                m_seq[t]  = m_cnt;
                m_pred[t] = pred;
                m_idx[t]  = pc_idx(pc);
            end
        end
    endtask

    initial begin
        rst = 1'b1; dec_br_valid = 1'b0; dec_br_pc = 32'd0; dec_br_target = 32'd0;
        br_result_en = 1'b0; br_result_tag = 2'd0; br_result_addr = 32'd0; br_mis_taken = 1'b0;
        model_reset();

        // Reset, then first allocation
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h100, 32'h140, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("tp1_grant", {31'd0, dec_br_grant}, 32'd1);
        chk("tp1_next_pc", pred_next_pc, 32'h104);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("tp1_busy", {28'd0, tag_busy}, 32'h1);

        // Fill all tags, reject fifth, free tag 2 and reuse it
        cyc(1'b0, 1'b1, 32'h204, 32'h240, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h308, 32'h340, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h40c, 32'h440, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h510, 32'h540, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("tp2_full", {31'd0, tags_full}, 32'd1);
        chk("tp2_nogrant", {31'd0, dec_br_grant}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd2, 32'h30c, 1'b0);
        cyc(1'b0, 1'b1, 32'h614, 32'h640, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("tp2_busy", {28'd0, tag_busy}, 32'hb);
        chk("tp2_tag", {30'd0, dec_br_tag}, 32'd2);

        // Mispredict on the oldest tag kills the younger ones
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h104, 32'h180, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h108, 32'h180, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h10c, 32'h180, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 32'h200, 1'b1);
        chk("tp3_flush", {31'd0, flush_en}, 32'd1);
        chk("tp3_addr", flush_addr, 32'h200);
        chk("tp3_kill", {28'd0, flush_kill_mask}, 32'h6);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("tp3_busy", {28'd0, tag_busy}, 32'h0);

        // Train BHT entry for 0x100: 01 -> 10 -> 11
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h100, 32'h140, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 32'h140, 1'b1);
        cyc(1'b0, 1'b1, 32'h100, 32'h140, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("tp4_pred_a", {31'd0, dec_br_pred}, 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 32'h140, 1'b0);
        cyc(1'b0, 1'b1, 32'h100, 32'h140, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("tp4_pred_b", {31'd0, dec_br_pred}, 32'd1);
        chk("tp4_next_pc", pred_next_pc, 32'h140);

        // Request alongside a mispredict, then a result for a free tag
        cyc(1'b0, 1'b1, 32'h100, 32'h140, 1'b1, 2'd0, 32'h104, 1'b1);
        chk("tp5_nogrant", {31'd0, dec_br_grant}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd3, 32'h999, 1'b1);
        chk("tp5_noflush", {31'd0, flush_en}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);

        // Reset with three tags outstanding
        cyc(1'b0, 1'b1, 32'h100, 32'h140, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h204, 32'h240, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h308, 32'h340, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'h100, 32'h140, 1'b1, 2'd0, 32'h500, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("tp6_busy", {28'd0, tag_busy}, 32'h0);
        cyc(1'b0, 1'b1, 32'h100, 32'h140, 1'b0, 2'd0, 32'h0, 1'b0);
        chk("tp6_pred", {31'd0, dec_br_pred}, 32'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc, tgt;
            pc  = ($urandom_range(0, 15) == 0) ? 32'hffff_fffc : ($urandom & 32'h0000_01fc);
            tgt = $urandom;
            cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 3) != 0), pc, tgt,
                1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
